// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encodings, size defaults and address field helpers for the word cache
package cache_pkg;

    localparam int ADDR_W_DEF  = 19;
    localparam int INDEX_W_DEF = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_e;

    // Both helpers return the field right-justified; callers truncate to their own widths.
    function automatic logic [31:0] index_of(input logic [31:0] addr, input int index_w);
        return (addr >> 2) & ((32'd1 << index_w) - 32'd1);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] addr, input int addr_w, input int index_w);
        logic [31:0] mask;
        mask = (addr_w >= 32) ? '1 : ((32'd1 << addr_w) - 32'd1);
        return (addr & mask) >> (index_w + 2);
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// rtl/cache_line_array.sv - direct-mapped line storage: async hit/data lookup, one sync write port
module cache_line_array
    import cache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int TAG_W   = ADDR_W_DEF - INDEX_W_DEF - 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic [TAG_W-1:0]   rd_tag,
    output logic               hit,
    output logic [31:0]        rd_data,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [31:0]        wr_data,
    input  logic               set_valid
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    always_comb begin
        valid_d = valid_q;
        if (we && set_valid) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data contents are meaningless until their valid bit is set, so they are not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign hit     = valid_q[rd_index] && (tag_mem[rd_index] == rd_tag);
    assign rd_data = data_mem[rd_index];

endmodule

// File: rtl/sram_cache_controller.sv
// rtl/sram_cache_controller.sv - write-through no-allocate word cache in front of sram_controller; CACHE_STATS_EN adds hit/miss counters
module sram_cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r_en_in,
    input  logic        w_en_in,
    input  logic [31:0] address_in,
    input  logic [31:0] write_data_in,
    output logic [31:0] read_data_out,
    output logic        ready_out,
    output logic        sram_r_en_out,
    output logic        sram_w_en_out,
    output logic [31:0] sram_address_out,
    output logic [31:0] sram_write_data_out,
    input  logic [31:0] sram_read_data_in,
    input  logic        sram_ready_in
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count_out,
    output logic [31:0] miss_count_out
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    state_e             state_q;
    state_e             state_d;
    logic [INDEX_W-1:0] line_index;
    logic [TAG_W-1:0]   line_tag;
    logic               line_hit;
    logic [31:0]        line_data;
    logic               line_we;
    logic               line_set_valid;
    logic [31:0]        line_wr_data;

    assign line_index = INDEX_W'(index_of(address_in, INDEX_W));
    assign line_tag   = TAG_W'(tag_of(address_in, ADDR_W, INDEX_W));

    cache_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_lines (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (line_index),
        .rd_tag    (line_tag),
        .hit       (line_hit),
        .rd_data   (line_data),
        .we        (line_we),
        .wr_index  (line_index),
        .wr_tag    (line_tag),
        .wr_data   (line_wr_data),
        .set_valid (line_set_valid)
    );

    assign sram_address_out    = {address_in[31:2], 2'b00};
    assign sram_write_data_out = write_data_in;

    // While rst is high the outputs show the idle values regardless of any held request.
    always_comb begin
        state_d        = state_q;
        ready_out      = 1'b1;
        read_data_out  = '0;
        sram_r_en_out  = 1'b0;
        sram_w_en_out  = 1'b0;
        line_we        = 1'b0;
        line_set_valid = 1'b0;
        line_wr_data   = write_data_in;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (w_en_in) begin
                        ready_out = 1'b0;
                        state_d   = WR_THRU;
                    end else if (r_en_in) begin
                        if (line_hit) begin
                            read_data_out = line_data;
                        end else begin
                            ready_out = 1'b0;
                            state_d   = RD_MISS;
                        end
                    end
                end
                RD_MISS: begin
                    sram_r_en_out = 1'b1;
                    if (sram_ready_in) begin
                        read_data_out  = sram_read_data_in;
                        line_we        = 1'b1;
                        line_set_valid = 1'b1;
                        line_wr_data   = sram_read_data_in;
                        state_d        = IDLE;
                    end else begin
                        ready_out = 1'b0;
                    end
                end
                WR_THRU: begin
                    sram_w_en_out = 1'b1;
                    if (sram_ready_in) begin
                        line_we        = line_hit;
                        line_set_valid = line_hit;
                        state_d        = IDLE;
                    end else begin
                        ready_out = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef CACHE_STATS_EN
    logic        count_hit;
    logic        count_miss;
    logic [31:0] hit_count_q;
    logic [31:0] hit_count_d;
    logic [31:0] miss_count_q;
    logic [31:0] miss_count_d;

    assign count_hit  = (state_q == IDLE) && !rst && r_en_in && !w_en_in && line_hit;
    assign count_miss = (state_q == IDLE) && (state_d == RD_MISS);

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (count_hit && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (count_miss && (miss_count_q != 32'hFFFF_FFFF)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count_out  = hit_count_q;
    assign miss_count_out = miss_count_q;
`endif

endmodule

// File: tb/tb_sram_cache_controller.sv
// tb/tb_sram_cache_controller.sv - directed self-checking bench with SRAM responder and read scoreboard
module tb_sram_cache_controller;

    localparam int LAT    = 3;
    localparam int BUDGET = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_en_in;
    logic        w_en_in;
    logic [31:0] address_in;
    logic [31:0] write_data_in;
    logic [31:0] read_data_out;
    logic        ready_out;
    logic        sram_r_en_out;
    logic        sram_w_en_out;
    logic [31:0] sram_address_out;
    logic [31:0] sram_write_data_out;
    logic [31:0] sram_read_data_in;
    logic        sram_ready_in;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count_out;
    logic [31:0] miss_count_out;
`endif

    always #5 clk = ~clk;

    sram_cache_controller dut (
        .clk                 (clk),
        .rst                 (rst),
        .r_en_in             (r_en_in),
        .w_en_in             (w_en_in),
        .address_in          (address_in),
        .write_data_in       (write_data_in),
        .read_data_out       (read_data_out),
        .ready_out           (ready_out),
        .sram_r_en_out       (sram_r_en_out),
        .sram_w_en_out       (sram_w_en_out),
        .sram_address_out    (sram_address_out),
        .sram_write_data_out (sram_write_data_out),
        .sram_read_data_in   (sram_read_data_in),
        .sram_ready_in       (sram_ready_in)
`ifdef CACHE_STATS_EN
        ,
        .hit_count_out       (hit_count_out),
        .miss_count_out      (miss_count_out)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] sram_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];
    logic        m_valid  [64];
    logic [10:0] m_tag    [64];
    logic [31:0] exp_q    [$];
    bit          hit_q    [$];
    int          m_hits;
    int          m_misses;

    int          w_cycles;
    bit          w_ok;
    bit          w_saw_r;
    bit          w_saw_w;
    logic [31:0] w_data;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // SRAM model: completes after LAT cycles of a held enable with a one-cycle ready pulse.
    initial begin
        int cnt;
        logic [31:0] k;
        cnt = 0;
        sram_ready_in = 1'b0;
        sram_read_data_in = '0;
        forever begin
            @(posedge clk);
            #2;
            if (sram_ready_in || !(sram_r_en_out || sram_w_en_out)) begin
                sram_ready_in = 1'b0;
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= LAT) begin
                    k = sram_address_out;
                    sram_ready_in = 1'b1;
                    if (sram_r_en_out) begin
                        sram_read_data_in = sram_mem.exists(k) ? sram_mem[k] : init_word(k);
                    end
                    if (sram_w_en_out) begin
                        sram_mem[k] = sram_write_data_out;
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        w_cycles = 0;
        w_ok = 0;
        w_saw_r = 0;
        w_saw_w = 0;
        w_data = '0;
        w_addr = 'x;
        w_wdata = 'x;
        for (int i = 0; i < BUDGET; i++) begin
            #1;
            if (sram_r_en_out || sram_w_en_out) begin
                w_addr = sram_address_out;
                w_wdata = sram_write_data_out;
            end
            if (sram_r_en_out) w_saw_r = 1;
            if (sram_w_en_out) w_saw_w = 1;
            if (ready_out) begin
                w_data = read_data_out;
                w_ok = 1;
                break;
            end
            w_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_idle_ready"}, ready_out, 1'b1);
        check({tag, "_idle_data"}, read_data_out, 32'h0);
        check({tag, "_idle_en"}, {sram_r_en_out, sram_w_en_out}, 2'b00);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr);
        logic [5:0]  idx;
        logic [10:0] tg;
        bit          eh;
        logic [31:0] ed;
        idx = addr[7:2];
        tg  = addr[18:8];
        exp_q.push_back(ref_read(addr));
        hit_q.push_back(m_valid[idx] && (m_tag[idx] == tg));
        @(negedge clk);
        r_en_in = 1'b1;
        w_en_in = 1'b0;
        address_in = addr;
        wait_ready();
        check({tag, "_done"}, w_ok, 1'b1);
        ed = exp_q.pop_front();
        eh = hit_q.pop_front();
        if (w_ok) begin
            check({tag, "_data"}, w_data, ed);
            check({tag, "_sram_rd"}, w_saw_r, !eh);
            check({tag, "_sram_wr"}, w_saw_w, 1'b0);
            check({tag, "_stall"}, w_cycles, eh ? 0 : LAT);
            if (!eh) check({tag, "_sram_addr"}, w_addr, {addr[31:2], 2'b00});
        end
        if (eh) begin
            m_hits++;
        end else begin
            m_misses++;
            m_valid[idx] = 1'b1;
            m_tag[idx] = tg;
        end
        @(negedge clk);
        r_en_in = 1'b0;
        #1;
        check_idle(tag);
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data, input bit with_read);
        logic [31:0] k;
        k = {addr[31:2], 2'b00};
        @(negedge clk);
        w_en_in = 1'b1;
        r_en_in = with_read;
        address_in = addr;
        write_data_in = data;
        wait_ready();
        check({tag, "_done"}, w_ok, 1'b1);
        if (w_ok) begin
            check({tag, "_sram_wr"}, w_saw_w, 1'b1);
            check({tag, "_sram_rd"}, w_saw_r, 1'b0);
            check({tag, "_stall"}, w_cycles, LAT);
            check({tag, "_sram_addr"}, w_addr, k);
            check({tag, "_sram_wdata"}, w_wdata, data);
        end
        ref_mem[k] = data;
        @(negedge clk);
        w_en_in = 1'b0;
        r_en_in = 1'b0;
        #1;
        check({tag, "_mem"}, sram_mem.exists(k) ? sram_mem[k] : 32'hxxxx_xxxx, data);
        check_idle(tag);
    endtask

    initial begin
        rst = 1'b1;
        r_en_in = 1'b0;
        w_en_in = 1'b0;
        address_in = '0;
        write_data_in = '0;
        m_hits = 0;
        m_misses = 0;
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i] = '0;
        end
        #1;
        check_idle("reset");
`ifdef CACHE_STATS_EN
        check("reset_hits", hit_count_out, 32'd0);
        check("reset_misses", miss_count_out, 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_read("rd0_miss", 32'h0000_0000);
        do_read("rd0_hit", 32'h0000_0000);
        do_write("wr0_hit", 32'h0000_0000, 32'h3344_1122, 1'b0);
        do_read("rd0_after_wr", 32'h0000_0000);
        do_write("wr100_noalloc", 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
        do_read("rd100_fill", 32'h0000_0100);
        do_read("rd4_miss", 32'h0000_0004);
        do_read("rd104_conflict", 32'h0000_0104);
        do_read("rd107_lowbits", 32'h0000_0107);
        do_read("rd4_evicted", 32'h0000_0004);
        do_write("wr104_rw_prio", 32'h0000_0104, 32'h1234_5678, 1'b1);
        do_read("rd104_after_wr", 32'h0000_0104);

        @(negedge clk);
        r_en_in = 1'b1;
        address_in = 32'h0000_0208;
        @(negedge clk);
        #1;
        check("abort_in_miss_ren", sram_r_en_out, 1'b1);
        check("abort_in_miss_ready", ready_out, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle("abort_rst");
        r_en_in = 1'b0;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
        @(negedge clk);
        rst = 1'b0;

        do_read("rd208_after_abort", 32'h0000_0208);
        do_read("rd0_after_abort", 32'h0000_0000);
        do_read("st_miss_a", 32'h0000_0200);
        do_read("st_hit_a", 32'h0000_0200);
        do_read("st_hit_b", 32'h0000_0200);
        do_read("st_miss_b", 32'h0000_0300);
`ifdef CACHE_STATS_EN
        check("stats_hits", hit_count_out, m_hits);
        check("stats_misses", miss_count_out, m_misses);
`endif
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
